// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out framing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sipo_ctrl_pkg;

   localparam int DEF_WIDTH = 4;

   // Framer state: waiting for a start bit, or collecting data bits.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit left-shift register; new bit enters at the LSB.
// Latency: q reflects a shifted-in bit one clk after shift_en.
// Backpressure: none; holds its contents whenever shift_en is low.
module sipo_shift_reg
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             shift_en,
   input  logic             d_in,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   // Shift one bit in from the right on each enabled clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (shift_en) begin
         r_q <= {r_q[WIDTH-2:0], d_in};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start-bit framer: shifts WIDTH serial bits and presents them as a held word.
// Latency: word_out/word_valid update on the edge sampling the last data bit.
// Backpressure: valid/ready on word_out; a word completing while one is unaccepted is dropped and flagged in overrun.
module sipo_frame_ctrl
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d_in,
   input  logic             en,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             overrun,
   input  logic             clr_ovr
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_word;
   logic             r_vld;
   logic             r_ovr;
   logic             w_start;
   logic             w_shift_en;
   logic             w_last;
   logic [WIDTH-1:0] w_sr;
   logic [WIDTH-1:0] w_word;
   logic             w_drop;
   // The oldest bit falls off the top as the last data bit arrives; it is never part of a word.
   logic             w_unused_msb;

   sipo_shift_reg #(.WIDTH(WIDTH)) u_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (w_shift_en),
      .d_in     (d_in),
      .q        (w_sr)
   );

   // Completed word is formed from the register contents plus the bit on the line this cycle.
   assign w_word       = {w_sr[WIDTH-2:0], d_in};
   assign w_unused_msb = w_sr[WIDTH-1];
   assign w_drop       = w_last & r_vld & ~word_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and per-cycle strobes: start detection, shift enable, last-bit detect.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_shift_en  = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (en && d_in) begin
               w_start     = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (en) begin
               w_shift_en = 1'b1;
               if (r_cnt == CNT_W'(WIDTH-1)) begin
                  w_last      = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Bit counter: cleared on frame start, advanced per data bit, parked at 0 after the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_start || w_last) begin
         r_cnt <= '0;
      end else if (w_shift_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Output word register with valid/ready; a completion can replace a word accepted in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_vld  <= 1'b0;
      end else if (w_last && !w_drop) begin
         r_word <= w_word;
         r_vld  <= 1'b1;
      end else if (r_vld && word_ready) begin
         r_vld  <= 1'b0;
      end
   end

   // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovr <= 1'b0;
      end else if (w_drop) begin
         r_ovr <= 1'b1;
      end else if (clr_ovr) begin
         r_ovr <= 1'b0;
      end
   end

   assign word_out   = r_word;
   assign word_valid = r_vld;
   assign overrun    = r_ovr;
   assign busy       = (r_state == ST_SHIFT);

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framing controller that sequences a serial-in/parallel-out shift register. It detects a start bit on the serial line and shifts exactly WIDTH data bits into the shift register, one bit per enable strobe. It then transfers the assembled word to a held output register with a valid/ready handshake toward the downstream consumer. Overrun is reported when a new word completes before the previous one has been accepted.

## Interface
- WIDTH, 4: data bits per frame (≥2).
- CNT_W, $clog2(WIDTH): bit-counter width (derived; not overridden).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- d_in  in  1  serial data, sampled only when en=1.
- en  in  1  bit strobe; one serial bit per clk with en=1.
- word_out  out  WIDTH  assembled word, MSB = first data bit received.
- word_valid  out  1  word_out holds an unaccepted word.
- word_ready  in  1  consumer accepts word_out when word_valid=1.
- busy  out  1  frame in progress (state SHIFT).
- overrun  out  1  sticky: a completed word was dropped.
- clr_ovr  in  1  clears overrun.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE: en=1 & d_in=1 → SHIFT, bit counter ← 0; shift register untouched. en=1 & d_in=0 → stay (line idle). en=0 → stay.
- SHIFT: en=1 → shift register ← {sr[WIDTH-2:0], d_in}, counter +1. en=0 → hold everything (stall, unbounded).
- Last bit (SHIFT, en=1, counter==WIDTH-1) → state ← IDLE; completed word = {sr[WIDTH-2:0], d_in}.
- On completion:
  - word_valid=0, or word_valid=1 & word_ready=1 same cycle → word_out ← completed word, word_valid ← 1.
  - word_valid=1 & word_ready=0 → word dropped, word_out unchanged, overrun ← 1.
- Handshake: word_valid=1 & word_ready=1 with no completion → word_valid ← 0, word_out retains the last value.
- word_out stable while word_valid=1 and not accepted.
- overrun: set as above; cleared by clr_ovr. Set and clear in the same cycle → set wins.
- busy = (state==SHIFT), combinational from state register.
- Counter arithmetic is unsigned CNT_W bits and never wraps past WIDTH-1; it is reset to 0 on entry to SHIFT.
- A start bit is recognised only in IDLE. A '1' arriving the cycle after completion starts the next frame with no gap required.

## Timing
- Reset (async assert, sync-released): state=IDLE, counter=0, shift register=0, word_out=0, word_valid=0, busy=0, overrun=0.
- Reset mid-frame aborts the frame; no partial word is ever presented.
- Latency: word_valid and word_out update on the same clk edge that samples the last data bit. Minimum frame = WIDTH+1 en cycles (start + data).
- Throughput: one word per WIDTH+1 en-strobes, back-to-back, provided the consumer accepts within WIDTH+1 cycles.
- All outputs are registered except busy (decode of the state register).

## Structure
- Shared package/header sipo_ctrl_pkg: state encoding localparams (ST_IDLE=1'b0, ST_SHIFT=1'b1), default WIDTH.
- Sub-module sipo_shift_reg: WIDTH-bit left-shift register with shift-enable (clk, rst_n, shift_en, d_in, q). The controller instantiates it and owns the FSM, counter, output register and flags.

## Test plan
- Basic frame (WIDTH=4, en=1 every cycle, word_ready=1): d_in = 0,0,1,1,0,1,0 → idle zeros ignored; word_out=4'b1010, word_valid=1 for exactly one cycle after the 7th edge; busy high for 4 cycles.
- Stalled frame: same bits as the basic frame with en=0 for 3 cycles between data bits 2 and 3 → identical word 4'b1010, completion delayed by 3 cycles, no extra shifts.
- Backpressure/overrun: word_ready=0, two frames 1,1,1,0,0 then 1,0,1,0,1 → word_out stays 4'b1100, overrun=1; clr_ovr pulse → overrun=0.
- Simultaneous accept+complete: word_valid=1 holding 4'b0011; word_ready=1 on the cycle the next frame's last bit lands (new word 4'b0110) → word_out=4'b0110, word_valid stays 1, overrun stays 0.
- Reset mid-frame: assert rst_n=0 after 2 data bits → all outputs 0 immediately (async). After release, a full frame 1,1,0,0,1 → 4'b1001 with no residue from the aborted frame.
- Back-to-back frames: start bit in the cycle immediately after completion → second word valid exactly 5 cycles later; with word_ready=1 there is no overrun.
